// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the MEM stage and a single-port sync RAM (DMEM_ALIGN_CHECK_EN adds misalign trap).
// Latency: 3+WAIT_STATES cycles per access; mem_din registered, valid in the DONE cycle.
// Backpressure: mem_stall holds the pipeline from request until DONE; requests are not sampled outside IDLE.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_dout,
    output logic [31:0]           mem_din,
    output logic                  mem_stall,
    output logic                  align_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wait_cnt;
    logic       req;
    logic       misaligned;
    logic       last_cyc;
    logic       unused_addr;

    assign req = mem_ren | mem_wen;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        last_cyc  = 1'b0;
        case (state)
            IDLE: begin
                // Reset forces the stall low even if the MEM stage still presents a request.
                mem_stall = req & ~rst;
                if (req) begin
                    state_nxt = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (WAIT_STATES == 0) begin
                    state_nxt = DONE;
                    last_cyc  = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (wait_cnt == 3'd1) begin
                    state_nxt = DONE;
                    last_cyc  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            mem_din   <= '0;
            align_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            ram_en    <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            align_err <= 1'b1;
                        end else begin
                            // A simultaneous read+write is treated as a write.
                            ram_en    <= 1'b1;
                            ram_we    <= mem_wen;
                            ram_addr  <= mem_addr[ADDR_WIDTH+1:2];
                            ram_wdata <= mem_dout;
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= 3'(WAIT_STATES);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
                default: begin
                end
            endcase
            if (last_cyc && !ram_we) begin
                mem_din <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_dmem_ctrl;

    localparam int AW = 10;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0]         mem_ren, mem_wen, mem_stall, align_err, ram_en, ram_we;
    logic [1:0][31:0]   mem_addr, mem_dout, mem_din, ram_wdata;
    logic [1:0][AW-1:0] ram_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] mem [1024];
        logic [31:0] rd;

        dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(g == 0 ? 2 : 0)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_ren   (mem_ren[g]),
            .mem_wen   (mem_wen[g]),
            .mem_addr  (mem_addr[g]),
            .mem_dout  (mem_dout[g]),
            .mem_din   (mem_din[g]),
            .mem_stall (mem_stall[g]),
            .align_err (align_err[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (rd)
        );

        initial begin
            rd = 32'h0;
            for (int j = 0; j < 1024; j++) mem[j] = 32'h0;
        end
        always @(posedge clk) if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
        // Read data follows the issued address and is held until the next enable.
        always @(ram_en[g] or ram_addr[g]) if (ram_en[g]) rd = mem[ram_addr[g]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of each instance.
    int          k     [2] = '{-1, -1};
    int          tot   [2];
    bit          m_wr  [2];
    bit          m_mis [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_dat [2];
    logic [31:0] exp_din[2] = '{32'h0, 32'h0};
    logic [31:0] ref_mem[2][1024];

    function automatic int ws(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AW));
    endfunction

    initial for (int i = 0; i < 2; i++) for (int j = 0; j < 1024; j++) ref_mem[i][j] = 32'h0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] = -1;
                exp_din[i] = 32'h0;
                chk("rst_stall", 32'(mem_stall[i]), 32'h0);
                chk("rst_ram_en", 32'(ram_en[i]), 32'h0);
                chk("rst_ram_we", 32'(ram_we[i]), 32'h0);
                chk("rst_ram_addr", 32'(ram_addr[i]), 32'h0);
                chk("rst_ram_wdata", ram_wdata[i], 32'h0);
                chk("rst_mem_din", mem_din[i], 32'h0);
                chk("rst_align_err", 32'(align_err[i]), 32'h0);
            end else begin
                if (k[i] < 0 && (mem_ren[i] || mem_wen[i])) begin
                    k[i]      = 0;
                    m_wr[i]   = mem_wen[i];
                    m_addr[i] = mem_addr[i];
                    m_dat[i]  = mem_dout[i];
                    m_mis[i]  = ALIGN && (mem_addr[i] % 4 != 0);
                    tot[i]    = m_mis[i] ? 2 : 3 + ws(i);
                    if (m_wr[i] && !m_mis[i]) ref_mem[i][widx(m_addr[i])] = m_dat[i];
                end
                if (k[i] >= 0 && k[i] == tot[i] - 1 && !m_wr[i] && !m_mis[i])
                    exp_din[i] = ref_mem[i][widx(m_addr[i])];
                chk("stall", 32'(mem_stall[i]), 32'(k[i] >= 0 && k[i] < tot[i] - 1));
                chk("ram_en", 32'(ram_en[i]), 32'(k[i] == 1 && !m_mis[i]));
                chk("align_err", 32'(align_err[i]), 32'(k[i] == 1 && m_mis[i]));
                chk("mem_din", mem_din[i], exp_din[i]);
                if (k[i] >= 1 && !m_mis[i]) begin
                    chk("ram_addr", 32'(ram_addr[i]), 32'(widx(m_addr[i])));
                    chk("ram_we", 32'(ram_we[i]), 32'(m_wr[i]));
                    if (m_wr[i]) chk("ram_wdata", ram_wdata[i], m_dat[i]);
                end
                if (k[i] >= 0) begin
                    k[i]++;
                    if (k[i] == tot[i]) k[i] = -1;
                end
            end
        end
    end

    // Runs one access on instance i; results are sampled mid-cycle.
    task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit drop,
                          output int n_stall, output int en_cnt, output int en_cyc,
                          output int ae_cnt, output int ae_cyc, output logic [31:0] din,
                          output logic [31:0] en_addr, output bit en_we);
        bit done = 0;
        n_stall = 0; en_cnt = 0; en_cyc = -1; ae_cnt = 0; ae_cyc = -1;
        din = 32'h0; en_addr = 32'h0; en_we = 0;
        mem_ren[i] = r; mem_wen[i] = w; mem_addr[i] = a; mem_dout[i] = d;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (mem_stall[i]) n_stall++;
            if (ram_en[i]) begin
                en_cnt++; en_cyc = cyc; en_addr = 32'(ram_addr[i]); en_we = ram_we[i];
            end
            if (align_err[i]) begin
                ae_cnt++; ae_cyc = cyc;
            end
            if (!mem_stall[i]) begin
                din = mem_din[i];
                done = 1;
                break;
            end
            if (drop && cyc == 0) begin
                @(posedge clk); #1;
                mem_ren[i] = 0; mem_wen[i] = 0;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL access_timeout: inst %0d addr %h still stalled after 20 cycles", i, a);
        end
        @(posedge clk); #1;
        mem_ren[i] = 0; mem_wen[i] = 0;
    endtask

    int ns, ec, ecy, ac, acy;
    logic [31:0] din, ea;
    bit ew;

    initial begin
        rst = 1'b1;
        mem_ren = '0; mem_wen = '0; mem_addr = '0; mem_dout = '0;
        #3;
        chk("init_stall", 32'(mem_stall[0]), 32'h0);
        chk("init_ram_en", 32'(ram_en[0]), 32'h0);
        chk("init_ram_addr", 32'(ram_addr[0]), 32'h0);
        chk("init_mem_din", mem_din[0], 32'h0);
        chk("init_align_err", 32'(align_err[0]), 32'h0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // WAIT_STATES=2
        access(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("wr_stall_cycles", ns, 4);
        chk("wr_en_count", ec, 1);
        chk("wr_en_cycle", ecy, 1);
        chk("wr_ram_addr", ea, 4);
        chk("wr_ram_we", 32'(ew), 1);
        access(0, 1, 0, 32'h0000_0010, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("rd_data", din, 32'hDEAD_BEEF);
        chk("rd_stall_cycles", ns, 4);
        chk("rd_ram_we", 32'(ew), 0);
        access(0, 1, 1, 32'h0000_0020, 32'h0000_1234, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("rw_din_unchanged", din, 32'hDEAD_BEEF);
        chk("rw_is_write", 32'(ew), 1);
        access(0, 1, 0, 32'h0000_0020, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("rw_readback", din, 32'h0000_1234);
        access(0, 1, 1, 32'h0000_0024, 32'h0000_5678, 1, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("drop_wr_stall", ns, 4);
        access(0, 1, 0, 32'h0000_0024, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("drop_wr_readback", din, 32'h0000_5678);
        access(0, 1, 0, 32'h0000_1010, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("upper_bits_ignored", din, 32'hDEAD_BEEF);
        access(0, 1, 0, 32'h0000_0020, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        access(0, 1, 0, 32'h0000_0013, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_din_unchanged", din, 32'h0000_1234);
        chk("mis_no_ram_en", ec, 0);
        chk("mis_align_err_count", ac, 1);
        chk("mis_align_err_cycle", acy, 1);
        chk("mis_stall_cycles", ns, 1);
`else
        chk("unaligned_reads_word4", din, 32'hDEAD_BEEF);
        chk("unaligned_ram_addr", ea, 4);
        chk("unaligned_no_align_err", ac, 0);
`endif

        // WAIT_STATES=0: back-to-back accesses
        access(1, 0, 1, 32'h0000_0000, 32'h1111_1111, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        access(1, 0, 1, 32'h0000_0004, 32'h2222_2222, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        access(1, 1, 0, 32'h0000_0000, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("ws0_rd0_data", din, 32'h1111_1111);
        chk("ws0_rd0_stall", ns, 2);
        chk("ws0_rd0_en_count", ec, 1);
        access(1, 1, 0, 32'h0000_0004, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("ws0_rd4_data", din, 32'h2222_2222);
        chk("ws0_rd4_en_cycle", ecy, 1);

        // Asynchronous reset in the middle of a WAIT cycle
        @(posedge clk); #1;
        mem_ren[0] = 1; mem_wen[0] = 0; mem_addr[0] = 32'h0000_0010;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_stall", 32'(mem_stall[0]), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(mem_stall[0]), 0);
        chk("async_rst_din", mem_din[0], 32'h0);
        chk("async_rst_ram_en", 32'(ram_en[0]), 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        mem_ren[0] = 0;
        access(0, 1, 0, 32'h0000_0024, 32'h0, 0, ns, ec, ecy, ac, acy, din, ea, ew);
        chk("post_rst_read", din, 32'h0000_5678);
        chk("post_rst_stall", ns, 4);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
